sm_regdump_uart: RTL and testbench

Register-dump transmitter for the schoolMIPS board tops. It runs a debug read scan over the core's `regAddr`/`regData` port, which the board tops otherwise drive from switches to LEDs. On a start pulse it walks all 32 registers and serialises each one as an ASCII hex line over a UART 8N1 TX pin, so a host terminal gets a full register snapshot. It sits in the board top beside `sm_top` and owns `regAddr` while busy.

---
 rtl/sm_regdump_uart.sv | 152 +++++++++++++++
 tb/tb_sm_regdump_uart.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_regdump_uart.sv
// sm_regdump_uart: walks the schoolMIPS register file and streams every
// register as an "AA=DDDDDDDD\r\n" ASCII line on a UART 8N1 TX pin.
module sm_regdump_uart #(
  parameter int BAUD_DIV = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [4:0]  regAddr,
  input  logic [31:0] regData,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_MAX = BW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LATCH,
    S_TX,
    S_NEXT
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    addr_q, addr_d;
  logic [31:0]   snap_q, snap_d;
  logic [3:0]    idx_q, idx_d;
  logic [3:0]    bit_q, bit_d;
  logic [BW-1:0] baud_q, baud_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;

  logic [7:0] chr;
  logic [2:0] nib_sel;
  logic [3:0] nib;
  logic [2:0] data_sel;
  logic       bit_val;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Character slots 3..10 carry the snapshot, MSB nibble first.
  always_comb begin
    nib_sel = 3'(4'd10 - idx_q);
    nib     = snap_q[{nib_sel, 2'b00} +: 4];
    chr     = hex_char(nib);
    case (idx_q)
      4'd0:    chr = hex_char({3'b000, addr_q[4]});
      4'd1:    chr = hex_char(addr_q[3:0]);
      4'd2:    chr = 8'h3D;
      4'd11:   chr = 8'h0D;
      4'd12:   chr = 8'h0A;
      default: chr = hex_char(nib);
    endcase
  end

  // Frame slot 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
  always_comb begin
    data_sel = 3'(bit_q - 4'd1);
    bit_val  = 1'b1;
    if (bit_q == 4'd0) begin
      bit_val = 1'b0;
    end else if (bit_q <= 4'd8) begin
      bit_val = chr[data_sel];
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    tx_d    = 1'b1;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = 5'd0;
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        snap_d  = regData;
        idx_d   = 4'd0;
        bit_d   = 4'd0;
        baud_d  = '0;
        state_d = S_TX;
      end
      S_TX: begin
        tx_d = bit_val;
        if (baud_q == BAUD_MAX) begin
          baud_d = '0;
          if (bit_q == 4'd9) begin
            bit_d = 4'd0;
            if (idx_q == 4'd12) begin
              state_d = S_NEXT;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_NEXT: begin
        if (addr_q == 5'd31) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          addr_d  = addr_q + 5'd1;
          state_d = S_LATCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= 5'd0;
      snap_q  <= 32'd0;
      idx_q   <= 4'd0;
      bit_q   <= 4'd0;
      baud_q  <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign regAddr = addr_q;
  assign tx      = tx_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;

endmodule

// File: tb/tb_sm_regdump_uart.sv
// Bench for sm_regdump_uart: a UART monitor decodes tx and pops the
// expected byte scoreboard; scenario tasks check timing and handshake.
module tb_sm_regdump_uart;

  localparam int BD = 4;
  localparam int P  = 130 * BD + 2;

  logic        clk;
  logic        rst;
  logic        start;
  logic        tx;
  logic        busy;
  logic        done;
  logic [4:0]  reg_addr;
  logic [31:0] reg_data;

  logic [31:0] mem [32];
  logic        noise_en;
  logic        clk_run;
  logic [31:0] ecnt = '0;
  logic [7:0]  sb [$];
  int          n_cmp;
  int          n_mis;

  logic        have_sb;
  logic [31:0] sb_e;
  logic [31:0] e_n;
  logic [31:0] e_d;
  logic        pb;
  logic [7:0]  rx_b;
  logic [7:0]  rx_exp;
  logic        rx_ok;
  logic        rx_ab;

  sm_regdump_uart #(.BAUD_DIV(BD)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .regAddr (reg_addr),
    .regData (reg_data),
    .tx      (tx),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  always @(posedge clk) ecnt <= ecnt + 32'd1;

  // Noise mode changes the register value on every clock.
  assign reg_data = noise_en ? (32'h9E3779B9 * ecnt) : mem[reg_addr];

  function automatic logic [7:0] hx(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  task automatic push_line(input logic [4:0] r, input logic [31:0] v);
    sb.push_back(hx({3'b000, r[4]}));
    sb.push_back(hx(r[3:0]));
    sb.push_back(8'h3D);
    for (int i = 7; i >= 0; i--) sb.push_back(hx(v[i*4 +: 4]));
    sb.push_back(8'h0D);
    sb.push_back(8'h0A);
  endtask

  // UART monitor: every bit must hold for exactly BD cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && tx === 1'b0) begin
        rx_ok = 1'b1;
        rx_ab = 1'b0;
        if (!have_sb) begin
          have_sb = 1'b1;
          sb_e    = ecnt;
        end
        for (int k = 1; k < BD; k++) begin
          @(negedge clk);
          if (rst !== 1'b0) rx_ab = 1'b1;
          if (tx !== 1'b0) rx_ok = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          if (rst !== 1'b0) rx_ab = 1'b1;
          rx_b[i] = tx;
          for (int k = 1; k < BD; k++) begin
            @(negedge clk);
            if (rst !== 1'b0) rx_ab = 1'b1;
            if (tx !== rx_b[i]) rx_ok = 1'b0;
          end
        end
        for (int k = 0; k < BD; k++) begin
          @(negedge clk);
          if (rst !== 1'b0) rx_ab = 1'b1;
          if (tx !== 1'b1) rx_ok = 1'b0;
        end
        if (!rx_ab) begin
          n_cmp++;
          if (sb.size() == 0) begin
            n_mis++;
            $display("FAIL uart_extra: got byte %h, none expected", rx_b);
          end else begin
            rx_exp = sb.pop_front();
            if (rx_b !== rx_exp || !rx_ok) begin
              n_mis++;
              $display("FAIL uart_byte: got %h (timing ok=%0b) want %h",
                       rx_b, rx_ok, rx_exp);
            end
          end
        end
      end
    end
  end

  task automatic do_start();
    have_sb = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e_n = ecnt;
  endtask

  task automatic wait_done(output logic [31:0] ed, output logic prev_busy);
    int t;
    t = 0;
    prev_busy = 1'b0;
    while (done !== 1'b1 && t < 20000) begin
      prev_busy = busy;
      @(negedge clk);
      t++;
    end
    ed = ecnt;
  endtask

  task automatic test_reset();
    int bad;
    clk_run  = 1'b0;
    start    = 1'b0;
    noise_en = 1'b0;
    rst      = 1'b0;
    #2 rst = 1'b1;
    #3;
    n_cmp++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || reg_addr !== 5'd0) begin
      n_mis++;
      $display("FAIL reset_vals: tx=%b busy=%b done=%b addr=%0d want 1 0 0 0",
               tx, busy, done, reg_addr);
    end
    clk_run = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_mis++;
      $display("FAIL idle_tx: %0d bad cycles, want 0", bad);
    end
  endtask

  task automatic test_single_line();
    int t;
    for (int r = 0; r < 32; r++) mem[r] = 32'h1000_0000 + 32'(r);
    sb.delete();
    for (int r = 0; r < 32; r++) push_line(5'(r), mem[r]);
    do_start();
    n_cmp++;
    if (busy !== 1'b1 || reg_addr !== 5'd0) begin
      n_mis++;
      $display("FAIL start_accept: busy=%b addr=%0d want 1 0", busy, reg_addr);
    end
    t = 0;
    while (!have_sb && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (!have_sb || (sb_e - e_n) != 32'd2) begin
      n_mis++;
      $display("FAIL first_start_bit: seen=%b offset=%0d want 1 2",
               have_sb, sb_e - e_n);
    end
    t = 0;
    while (sb.size() > 416 - 13 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (sb.size() > 416 - 13) begin
      n_mis++;
      $display("FAIL first_line: %0d bytes left want %0d", sb.size(), 403);
    end
  endtask

  // Reset lands on data bit 1 (a zero) of byte '1' in line "02=10000002".
  task automatic test_reset_mid();
    int t;
    t = 0;
    while (ecnt < sb_e + 32'(2 * P + 32 * BD + 1) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (tx !== 1'b0) begin
      n_mis++;
      $display("FAIL mid_bit: tx=%b want 0 before reset", tx);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (tx !== 1'b1 || busy !== 1'b0 || reg_addr !== 5'd0) begin
      n_mis++;
      $display("FAIL async_reset: tx=%b busy=%b addr=%0d want 1 0 0",
               tx, busy, reg_addr);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (tx !== 1'b1 || busy !== 1'b0 || reg_addr !== 5'd0) begin
      n_mis++;
      $display("FAIL after_reset: tx=%b busy=%b addr=%0d want 1 0 0",
               tx, busy, reg_addr);
    end
    sb.delete();
    repeat (60) @(negedge clk);
  endtask

  task automatic test_full_dump();
    for (int r = 0; r < 32; r++) mem[r] = 32'(r) * 32'h1111_1111;
    mem[5]  = 32'hDEAD_BEEF;
    mem[10] = 32'h0000_000A;
    sb.delete();
    for (int r = 0; r < 32; r++) push_line(5'(r), mem[r]);
    do_start();
    wait_done(e_d, pb);
    n_cmp++;
    if (done !== 1'b1) begin
      n_mis++;
      $display("FAIL done_seen: done=%b want 1", done);
    end
    n_cmp++;
    if (have_sb !== 1'b1 || (sb_e - e_n) != 32'd2) begin
      n_mis++;
      $display("FAIL dump_first_bit: offset=%0d want 2", sb_e - e_n);
    end
    n_cmp++;
    if ((e_d - e_n) != 32'(32 * P)) begin
      n_mis++;
      $display("FAIL done_time: %0d cycles after start want %0d",
               e_d - e_n, 32 * P);
    end
    n_cmp++;
    if (busy !== 1'b0 || pb !== 1'b1) begin
      n_mis++;
      $display("FAIL busy_fall: busy=%b prev=%b want 0 1", busy, pb);
    end
    n_cmp++;
    if (reg_addr !== 5'd31) begin
      n_mis++;
      $display("FAIL addr_hold: addr=%0d want 31", reg_addr);
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_mis++;
      $display("FAIL dump_bytes: %0d left want 0", sb.size());
    end
  endtask

  // Starts in the done cycle, so this is also the back-to-back case.
  task automatic test_back_to_back_snapshot();
    for (int r = 0; r < 32; r++) mem[r] = 32'hC0DE_0000 ^ (32'(r) << 3);
    sb.delete();
    have_sb  = 1'b0;
    noise_en = 1'b1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e_n   = ecnt;
    push_line(5'd0, 32'h9E3779B9 * e_n);
    for (int r = 1; r < 32; r++) push_line(5'(r), mem[r]);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b1 || reg_addr !== 5'd0) begin
      n_mis++;
      $display("FAIL restart: done=%b busy=%b addr=%0d want 0 1 0",
               done, busy, reg_addr);
    end
    repeat (300) @(negedge clk);
    noise_en = 1'b0;
    repeat (5 * P) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(e_d, pb);
    n_cmp++;
    if (done !== 1'b1 || (e_d - e_n) != 32'(32 * P)) begin
      n_mis++;
      $display("FAIL ignore_start: done=%b at %0d want 1 at %0d",
               done, e_d - e_n, 32 * P);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      n_mis++;
      $display("FAIL snap_bytes: %0d left busy=%b want 0 0", sb.size(), busy);
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_mis   = 0;
    have_sb = 1'b0;
    sb_e    = '0;
    for (int r = 0; r < 32; r++) mem[r] = '0;
    test_reset();
    test_single_line();
    test_reset_mid();
    test_full_dump();
    test_back_to_back_snapshot();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
